return_addr_stack: RTL and testbench



---
 rtl/kgp_rics_pkg.sv | 11 +
 rtl/return_addr_stack_ras_mem.sv | 22 ++
 rtl/return_addr_stack.sv | 95 +++++++++
 tb/tb_return_addr_stack.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_rics_pkg.sv
// Shared KGP-RICS decode constants used by the branch unit and the return-address stack.
package kgp_rics_pkg;

   localparam logic [2:0] BR_JUMP = 3'b001;
   localparam logic [2:0] BR_CALL = 3'b101;

   localparam logic [5:0] FN_RET = 6'b000001;

   localparam int unsigned DEFAULT_AW = 32;

endpackage

// File: rtl/return_addr_stack_ras_mem.sv
// ras_mem: DEPTH x AW register file, one synchronous write port, one combinational read port.
module ras_mem #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [AW-1:0]            wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [AW-1:0]            rdata
);

   logic [AW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Return-address stack: push link address on calls, pop on returns.
// Macro RAS_WRAP_EN: when defined, a push while full overwrites the oldest entry; otherwise it is dropped.
module return_addr_stack
   import kgp_rics_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = DEFAULT_AW
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     instr_valid,
   input  logic [2:0]               branch,
   input  logic [5:0]               fn_code,
   input  logic [AW-1:0]            pc_value,
   input  logic                     flush,
   output logic [AW-1:0]            return_addr,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int unsigned SPW = $clog2(DEPTH);
   localparam int unsigned CW  = SPW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [SPW-1:0] sp;
   logic [CW-1:0]  cnt;
   logic           ovf_q;
   logic           unf_q;
   logic           push;
   logic           pop;
   logic           do_write;
   logic [SPW-1:0] rd_idx;
   logic [AW-1:0]  rd_data;

   assign push = instr_valid && (branch == BR_CALL);
   assign pop  = instr_valid && (branch == BR_JUMP) && (fn_code == FN_RET);

   assign full  = (cnt == FULL_CNT);
   assign empty = (cnt == '0);

`ifdef RAS_WRAP_EN
   assign do_write = push && !flush;
`else
   assign do_write = push && !flush && !full;
`endif

   assign rd_idx = sp - 1'b1;

   ras_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (do_write),
      .waddr (sp),
      .wdata (pc_value + 1'b1),
      .raddr (rd_idx),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp    <= '0;
         cnt   <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (flush) begin
         sp    <= '0;
         cnt   <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (push) begin
         // do_write already folds in the full/wrap policy; count saturates either way
         if (do_write) sp <= sp + 1'b1;
         if (!full) cnt <= cnt + 1'b1;
         else       ovf_q <= 1'b1;
      end else if (pop) begin
         if (!empty) begin
            sp  <= sp - 1'b1;
            cnt <= cnt - 1'b1;
         end else begin
            unf_q <= 1'b1;
         end
      end
   end

   assign return_addr = empty ? '0 : rd_data;
   assign count       = cnt;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed self-checking bench for return_addr_stack (DEPTH=8, AW=32); honours RAS_WRAP_EN.
module tb_return_addr_stack;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [2:0]  branch;
   logic [5:0]  fn_code;
   logic [31:0] pc_value;
   logic        flush;
   logic [31:0] return_addr;
   logic        empty;
   logic        full;
   logic [3:0]  count;
   logic        overflow;
   logic        underflow;

   int checks   = 0;
   int failures = 0;

   return_addr_stack #(
      .DEPTH (8),
      .AW    (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .branch      (branch),
      .fn_code     (fn_code),
      .pc_value    (pc_value),
      .flush       (flush),
      .return_addr (return_addr),
      .empty       (empty),
      .full        (full),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      branch      = 3'b000;
      fn_code     = 6'b000000;
      flush       = 1'b0;
   endtask

   task automatic do_call(input logic [31:0] pc);
      instr_valid = 1'b1;
      branch      = 3'b101;
      fn_code     = 6'b000000;
      pc_value    = pc;
      step();
   endtask

   task automatic do_ret();
      instr_valid = 1'b1;
      branch      = 3'b001;
      fn_code     = 6'b000001;
      step();
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2;
      checks++;
      if (return_addr !== 32'h0 || count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 ||
          overflow !== 1'b0 || underflow !== 1'b0) begin
         failures++;
         $display("FAIL reset: ra=%h cnt=%0d e=%b f=%b ovf=%b unf=%b, want ra=0 cnt=0 e=1 f=0 ovf=0 unf=0",
                  return_addr, count, empty, full, overflow, underflow);
      end
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_push_pop();
      do_call(32'h10);
      do_call(32'h20);
      do_call(32'h30);
      checks++;
      if (return_addr !== 32'h31 || count !== 4'd3 || empty !== 1'b0) begin
         failures++;
         $display("FAIL push3: ra=%h cnt=%0d e=%b, want ra=31 cnt=3 e=0", return_addr, count, empty);
      end
      // return_addr is readable in the return cycle itself
      instr_valid = 1'b1;
      branch      = 3'b001;
      fn_code     = 6'b000001;
      #1;
      checks++;
      if (return_addr !== 32'h31) begin
         failures++;
         $display("FAIL ret_same_cycle: ra=%h want 31", return_addr);
      end
      step();
      checks++;
      if (return_addr !== 32'h21 || count !== 4'd2) begin
         failures++;
         $display("FAIL pop1: ra=%h cnt=%0d want ra=21 cnt=2", return_addr, count);
      end
      do_ret();
      checks++;
      if (return_addr !== 32'h11 || count !== 4'd1) begin
         failures++;
         $display("FAIL pop2: ra=%h cnt=%0d want ra=11 cnt=1", return_addr, count);
      end
      do_ret();
      checks++;
      if (return_addr !== 32'h0 || empty !== 1'b1 || underflow !== 1'b0) begin
         failures++;
         $display("FAIL pop3: ra=%h e=%b unf=%b want ra=0 e=1 unf=0", return_addr, empty, underflow);
      end
      do_call(32'hFFFF_FFFF);
      checks++;
      if (return_addr !== 32'h0 || count !== 4'd1) begin
         failures++;
         $display("FAIL pc_wrap: ra=%h cnt=%0d want ra=0 cnt=1", return_addr, count);
      end
      do_flush();
   endtask

   task automatic test_overflow();
      logic [31:0] exp;
      for (int i = 0; i < 8; i++) do_call(32'h100 + 32'(i));
      checks++;
      if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0 || return_addr !== 32'h108) begin
         failures++;
         $display("FAIL fill8: f=%b cnt=%0d ovf=%b ra=%h want f=1 cnt=8 ovf=0 ra=108",
                  full, count, overflow, return_addr);
      end
      do_call(32'h108);
`ifdef RAS_WRAP_EN
      exp = 32'h109;
`else
      exp = 32'h108;
`endif
      checks++;
      if (overflow !== 1'b1 || count !== 4'd8 || full !== 1'b1 || return_addr !== exp) begin
         failures++;
         $display("FAIL push9: ovf=%b cnt=%0d f=%b ra=%h want ovf=1 cnt=8 f=1 ra=%h",
                  overflow, count, full, return_addr, exp);
      end
      for (int k = 1; k < 8; k++) begin
         do_ret();
         checks++;
         if (return_addr !== exp - 32'(k) || count !== 4'(8 - k)) begin
            failures++;
            $display("FAIL ovf_pop%0d: ra=%h cnt=%0d want ra=%h cnt=%0d",
                     k, return_addr, count, exp - 32'(k), 8 - k);
         end
      end
`ifdef RAS_WRAP_EN
      exp = 32'h102;
`else
      exp = 32'h101;
`endif
      checks++;
      if (return_addr !== exp || count !== 4'd1 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL bottom: ra=%h cnt=%0d ovf=%b want ra=%h cnt=1 ovf=1", return_addr, count, overflow, exp);
      end
      do_flush();
      checks++;
      if (overflow !== 1'b0 || empty !== 1'b1) begin
         failures++;
         $display("FAIL flush_clr_ovf: ovf=%b e=%b want ovf=0 e=1", overflow, empty);
      end
   endtask

   task automatic test_underflow();
      do_ret();
      checks++;
      if (underflow !== 1'b1 || return_addr !== 32'h0 || count !== 4'd0 || empty !== 1'b1) begin
         failures++;
         $display("FAIL underflow: unf=%b ra=%h cnt=%0d e=%b want unf=1 ra=0 cnt=0 e=1",
                  underflow, return_addr, count, empty);
      end
      do_call(32'h40);
      checks++;
      if (return_addr !== 32'h41 || count !== 4'd1 || underflow !== 1'b1) begin
         failures++;
         $display("FAIL after_unf_push: ra=%h cnt=%0d unf=%b want ra=41 cnt=1 unf=1",
                  return_addr, count, underflow);
      end
      do_flush();
   endtask

   task automatic test_invalid();
      do_call(32'h70);
      instr_valid = 1'b0;
      branch      = 3'b101;
      pc_value    = 32'h80;
      step();
      checks++;
      if (count !== 4'd1 || return_addr !== 32'h71) begin
         failures++;
         $display("FAIL invalid_call: cnt=%0d ra=%h want cnt=1 ra=71", count, return_addr);
      end
      instr_valid = 1'b0;
      branch      = 3'b001;
      fn_code     = 6'b000001;
      step();
      checks++;
      if (count !== 4'd1 || return_addr !== 32'h71) begin
         failures++;
         $display("FAIL invalid_ret: cnt=%0d ra=%h want cnt=1 ra=71", count, return_addr);
      end
      instr_valid = 1'b1;
      branch      = 3'b001;
      fn_code     = 6'b000010;
      step();
      checks++;
      if (count !== 4'd1 || return_addr !== 32'h71 || underflow !== 1'b0) begin
         failures++;
         $display("FAIL jump_not_ret: cnt=%0d ra=%h unf=%b want cnt=1 ra=71 unf=0", count, return_addr, underflow);
      end
      do_flush();
   endtask

   task automatic test_flush();
      do_call(32'h10);
      do_call(32'h20);
      do_call(32'h30);
      flush       = 1'b1;
      instr_valid = 1'b1;
      branch      = 3'b101;
      pc_value    = 32'h90;
      step();
      checks++;
      if (count !== 4'd0 || empty !== 1'b1 || return_addr !== 32'h0) begin
         failures++;
         $display("FAIL flush_call: cnt=%0d e=%b ra=%h want cnt=0 e=1 ra=0", count, empty, return_addr);
      end
      do_call(32'h60);
      do_call(32'h61);
      do_ret();
      checks++;
      if (return_addr !== 32'h61 || count !== 4'd1) begin
         failures++;
         $display("FAIL post_flush: ra=%h cnt=%0d want ra=61 cnt=1", return_addr, count);
      end
      do_flush();
   endtask

   task automatic test_async_reset();
      do_ret();
      for (int i = 0; i < 5; i++) do_call(32'h200 + 32'(i));
      checks++;
      if (count !== 4'd5 || return_addr !== 32'h205 || underflow !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset: cnt=%0d ra=%h unf=%b want cnt=5 ra=205 unf=1", count, return_addr, underflow);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (count !== 4'd0 || empty !== 1'b1 || return_addr !== 32'h0 || underflow !== 1'b0 ||
          overflow !== 1'b0 || full !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: cnt=%0d e=%b ra=%h unf=%b ovf=%b f=%b want cnt=0 e=1 ra=0 unf=0 ovf=0 f=0",
                  count, empty, return_addr, underflow, overflow, full);
      end
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      instr_valid = 1'b0;
      branch      = 3'b000;
      fn_code     = 6'b000000;
      pc_value    = 32'h0;
      flush       = 1'b0;
      test_reset();
      test_push_pop();
      test_overflow();
      test_underflow();
      test_invalid();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
